// File: rtl/barcode_scan.sv
// Counts legal-width black bars on three scan rows and flags a barcode when enough rows pass.
// Row results appear 1 cycle after row close, the frame verdict 2 cycles after; no backpressure.
module barcode_scan #(
    parameter logic [9:0] SCAN_Y1   = 10'd80,
    parameter logic [9:0] SCAN_Y2   = 10'd100,
    parameter logic [9:0] SCAN_Y3   = 10'd130,
    parameter int         MIN_W     = 2,
    parameter int         MAX_W     = 12,
    parameter int         MIN_BARS  = 20,
    parameter int         PASS_ROWS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    input  logic       in_de,
    input  logic       in_data,
    output logic       scan_en,
    output logic [2:0] row_pass,
    output logic [7:0] bar_cnt_last,
    output logic       frame_done
);

    localparam logic [9:0] MIN_W_L    = 10'(MIN_W);
    localparam logic [9:0] MAX_W_L    = 10'(MAX_W);
    localparam logic [7:0] MIN_BARS_L = 8'(MIN_BARS);
    localparam logic [2:0] PASS_L     = 3'(PASS_ROWS);

    typedef enum logic [1:0] {IDLE, WHITE, BLACK} state_t;

    state_t     state;
    logic [9:0] run_len;
    logic [7:0] bar_cnt;
    logic       edge_flag;
    logic [1:0] row_idx;
    logic       armed;
    logic       eval_pend;

    logic       is_scan;
    logic [1:0] hit_idx;
    logic       bar_legal;
    logic [2:0] pass_cnt;

    // Column position is carried for debug visibility only.
    logic       x_in_unused;
    assign x_in_unused = ^x_in;

    always_comb begin
        is_scan = 1'b1;
        hit_idx = 2'd0;
        if (y_in == SCAN_Y1) begin
            hit_idx = 2'd0;
        end else if (y_in == SCAN_Y2) begin
            hit_idx = 2'd1;
        end else if (y_in == SCAN_Y3) begin
            hit_idx = 2'd2;
        end else begin
            is_scan = 1'b0;
        end
    end

    assign bar_legal = (run_len >= MIN_W_L) && (run_len <= MAX_W_L) && !edge_flag;
    assign pass_cnt  = 3'(row_pass[0]) + 3'(row_pass[1]) + 3'(row_pass[2]);

    // armed blocks a row that was already under way when reset released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            run_len      <= '0;
            bar_cnt      <= '0;
            edge_flag    <= 1'b0;
            row_idx      <= '0;
            armed        <= 1'b0;
            eval_pend    <= 1'b0;
            scan_en      <= 1'b0;
            row_pass     <= '0;
            bar_cnt_last <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            eval_pend  <= 1'b0;
            if (eval_pend) begin
                scan_en    <= (pass_cnt >= PASS_L);
                frame_done <= 1'b1;
            end
            if (!in_de) begin
                armed <= 1'b1;
            end

            if (in_de && is_scan && (state != IDLE || armed)) begin
                if (state == IDLE) begin
                    state     <= in_data ? BLACK : WHITE;
                    run_len   <= 10'd1;
                    bar_cnt   <= '0;
                    edge_flag <= 1'b1;
                    row_idx   <= hit_idx;
                    if (hit_idx == 2'd0) begin
                        row_pass <= '0;
                    end
                end else if ((state == BLACK) == in_data) begin
                    if (run_len != 10'h3FF) begin
                        run_len <= run_len + 10'd1;
                    end
                end else begin
                    if (state == BLACK && bar_legal && bar_cnt != 8'hFF) begin
                        bar_cnt <= bar_cnt + 8'd1;
                    end
                    state     <= in_data ? BLACK : WHITE;
                    run_len   <= 10'd1;
                    edge_flag <= 1'b0;
                end
            end else if (!in_de && state != IDLE) begin
                // Any black run still open here is clipped by the line edge and dropped.
                state                 <= IDLE;
                run_len               <= '0;
                edge_flag             <= 1'b0;
                bar_cnt_last          <= bar_cnt;
                row_pass[row_idx]     <= (bar_cnt >= MIN_BARS_L);
                if (row_idx == 2'd2) begin
                    eval_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_barcode_scan.sv
// Randomized and directed rows against a run-list reference model of the barcode scanner.
module tb_barcode_scan;

    localparam logic [9:0] Y1 = 10'd80;
    localparam logic [9:0] Y2 = 10'd100;
    localparam logic [9:0] Y3 = 10'd130;
    localparam int MIN_W = 2;
    localparam int MAX_W = 12;
    localparam int MIN_BARS = 20;
    localparam int PASS_ROWS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x_in;
    logic [9:0] y_in;
    logic       in_de;
    logic       in_data;
    logic       scan_en;
    logic [2:0] row_pass;
    logic [7:0] bar_cnt_last;
    logic       frame_done;

    always #5 clk = ~clk;

    barcode_scan dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x_in         (x_in),
        .y_in         (y_in),
        .in_de        (in_de),
        .in_data      (in_data),
        .scan_en      (scan_en),
        .row_pass     (row_pass),
        .bar_cnt_last (bar_cnt_last),
        .frame_done   (frame_done)
    );

    bit   pix [0:1023];
    int   plen;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   cmp_on = 1'b0;
    int   fd_seen = 0;

    logic       exp_scan_en;
    logic [2:0] exp_row_pass;
    logic [7:0] exp_bar;
    logic       exp_fd;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected legal-bar count straight from the run list of the row.
    function automatic int count_bars();
        int cnt = 0;
        int i = 0;
        while (i < plen) begin
            int s = i;
            while (i < plen && pix[i] == pix[s]) i++;
            if (pix[s] && s != 0 && i != plen && (i - s) >= MIN_W && (i - s) <= MAX_W)
                cnt++;
        end
        if (cnt > 255) cnt = 255;
        return cnt;
    endfunction

    task automatic clear_row();
        plen = 0;
    endtask

    task automatic add_run(input bit c, input int w);
        for (int k = 0; k < w; k++) begin
            if (plen < 1024) begin
                pix[plen] = c;
                plen++;
            end
        end
    endtask

    task automatic build_std();
        clear_row();
        add_run(1'b0, 1);
        for (int b = 0; b < 24; b++) begin
            add_run(1'b1, 4);
            add_run(1'b0, 4);
        end
        add_run(1'b0, 2);
    endtask

    task automatic build_white();
        clear_row();
        add_run(1'b0, 195);
    endtask

    task automatic build_widths();
        clear_row();
        add_run(1'b0, 1);
        for (int r = 0; r < 6; r++) begin
            add_run(1'b1, 1);  add_run(1'b0, 3);
            add_run(1'b1, 2);  add_run(1'b0, 3);
            add_run(1'b1, 12); add_run(1'b0, 3);
            add_run(1'b1, 13); add_run(1'b0, 3);
        end
    endtask

    task automatic build_clipped();
        clear_row();
        for (int b = 0; b < 20; b++) begin
            add_run(1'b1, 4);
            if (b != 19) add_run(1'b0, 4);
        end
    endtask

    task automatic build_toggle();
        clear_row();
        for (int k = 0; k < 101; k++) add_run(k[0] ? 1'b0 : 1'b1, 1);
    endtask

    task automatic build_random();
        bit c;
        int nr;
        int w;
        clear_row();
        c  = 1'($urandom_range(0, 1));
        nr = $urandom_range(20, 60);
        for (int r = 0; r < nr; r++) begin
            if (c) begin
                if ($urandom_range(0, 3) != 0) w = $urandom_range(MIN_W, MAX_W);
                else if ($urandom_range(0, 1) != 0) w = 1;
                else w = $urandom_range(13, 16);
            end else begin
                w = $urandom_range(1, 6);
            end
            add_run(c, w);
            c = !c;
        end
    endtask

    task automatic drive_row(input logic [9:0] y, input int rst_at);
        int cnt;
        int idx;
        bit aborted;
        aborted = 1'b0;
        cnt = count_bars();
        idx = (y == Y1) ? 0 : (y == Y2) ? 1 : (y == Y3) ? 2 : -1;
        for (int i = 0; i < plen; i++) begin
            @(posedge clk);
            if (!rst_n) begin
                exp_scan_en = 1'b0; exp_row_pass = '0; exp_bar = '0; exp_fd = 1'b0;
                aborted = 1'b1;
            end else if (i == 1 && idx == 0 && !aborted) begin
                exp_row_pass = 3'b000;
            end
            #1;
            in_de = 1'b1; in_data = pix[i]; x_in = 10'(i); y_in = y;
            if (rst_at >= 0 && i == rst_at) rst_n = 1'b0;
            else if (rst_at >= 0 && i == rst_at + 3) rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
        in_de = 1'b0; in_data = 1'b0;
        @(posedge clk);
        if (!aborted && idx >= 0) begin
            exp_bar = 8'(cnt);
            exp_row_pass[idx] = (cnt >= MIN_BARS);
        end
        @(posedge clk);
        if (!aborted && idx == 2) begin
            exp_scan_en = ($countones(exp_row_pass) >= PASS_ROWS);
            exp_fd = 1'b1;
        end
        @(posedge clk);
        exp_fd = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic std_frame();
        build_std();
        drive_row(Y1, -1);
        drive_row(Y2, -1);
        drive_row(Y3, -1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                if (frame_done === 1'b1) fd_seen++;
                check("scan_en", int'(scan_en), int'(exp_scan_en));
                check("row_pass", int'(row_pass), int'(exp_row_pass));
                check("bar_cnt_last", int'(bar_cnt_last), int'(exp_bar));
                check("frame_done", int'(frame_done), int'(exp_fd));
            end
        end
    end

    initial begin
        int fd0;
        rst_n = 1'b0; in_de = 1'b0; in_data = 1'b0; x_in = '0; y_in = '0;
        exp_scan_en = 1'b0; exp_row_pass = '0; exp_bar = '0; exp_fd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_on = 1'b1;
        @(negedge clk);
        check("reset_outputs", int'({scan_en, row_pass, bar_cnt_last, frame_done}), 0);

        // Full passing frame
        fd0 = fd_seen;
        build_std();
        drive_row(Y1, -1); @(negedge clk); check("std_y1_bars", int'(bar_cnt_last), 24);
        drive_row(Y2, -1); @(negedge clk); check("std_y2_bars", int'(bar_cnt_last), 24);
        drive_row(Y3, -1); @(negedge clk); check("std_y3_bars", int'(bar_cnt_last), 24);
        check("std_row_pass", int'(row_pass), 7);
        check("std_scan_en", int'(scan_en), 1);
        check("std_fd_pulses", fd_seen - fd0, 1);

        // Only Y1 carries a barcode
        build_std();   drive_row(Y1, -1);
        build_white(); drive_row(Y2, -1);
        drive_row(Y3, -1);
        @(negedge clk);
        check("y1only_row_pass", int'(row_pass), 1);
        check("y1only_bars", int'(bar_cnt_last), 0);
        check("y1only_scan_en", int'(scan_en), 0);

        // Width limits, edge-clipped bars, toggling pixels
        build_widths();  drive_row(Y1, -1); @(negedge clk); check("width_bars", int'(bar_cnt_last), 12);
        build_clipped(); drive_row(Y2, -1); @(negedge clk); check("clip_bars", int'(bar_cnt_last), 18);
        check("clip_pass_bit", int'(row_pass[1]), 0);
        build_toggle();  drive_row(Y3, -1); @(negedge clk); check("toggle_bars", int'(bar_cnt_last), 0);

        // Reset in the middle of Y2 after a passing frame
        std_frame();
        @(negedge clk); check("pre_reset_scan_en", int'(scan_en), 1);
        build_std();
        drive_row(Y1, -1);
        drive_row(Y2, 60);
        @(negedge clk);
        check("post_reset_outputs", int'({scan_en, row_pass, bar_cnt_last, frame_done}), 0);
        drive_row(Y3, -1);
        @(negedge clk); check("post_reset_y3_scan_en", int'(scan_en), 0);
        std_frame();
        @(negedge clk); check("recovered_scan_en", int'(scan_en), 1);

        // Randomized frames, with stray non-scan rows and occasional missing Y3
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                build_random();
                drive_row(10'($urandom_range(0, 79)), -1);
            end
            build_random(); drive_row(Y1, -1);
            build_random(); drive_row(Y2, -1);
            if ($urandom_range(0, 4) != 0) begin
                build_random(); drive_row(Y3, -1);
            end
        end

        repeat (2) @(posedge clk);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
